order_tx: RTL and testbench
===========================

Name: order_tx

Overview:
- Downstream of the strategy stage: captures each order word produced by the strategy wrapper (Order RCB data qualified by the FSM out-valid strobe).
- Buffers orders in a small FIFO.
- Serializes each 128-bit order into two 64-bit beats on an Avalon-ST-style ready/valid stream toward the order transmit MAC path.
- Strategy side has no backpressure; overflow is dropped and counted.

Parameters:
- ORD_WIDTH, 128, order word width from strategy; must equal 2*OUT_WIDTH.
- OUT_WIDTH, 64, output beat width.
- FIFO_DEPTH, 8, order FIFO entries; power of 2, >=2.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- sef_out_valid  input  1  one-cycle strobe: orcb_data holds a valid order
- orcb_data  input  ORD_WIDTH  order word from Order RCB
- ord_valid  output  1  output beat valid
- ord_ready  input  1  downstream accepts beat when high with ord_valid
- ord_data  output  OUT_WIDTH  output beat payload
- ord_sop  output  1  first beat of order
- ord_eop  output  1  last beat of order
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_cnt  output  DROP_CNT_WIDTH  orders dropped on full, saturating

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0: ord_valid=0, ord_data=0, sop=0, eop=0, fifo_level=0, drop_cnt=0.
  - FIFO pointers 0; FSM to IDLE.
- Push:
  - sef_out_valid=1 and fifo_level<FIFO_DEPTH: orcb_data is written at that rising edge.
  - If full, the order is dropped and drop_cnt increments; it saturates at all-ones.
  - Full is judged on the registered level before the edge. A push while full is dropped even if a pop occurs in the same cycle.
- Pointers: wrap modulo FIFO_DEPTH. Level is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE: FIFO non-empty -> pop into 128-bit hold register; drive ord_data=hold[127:64], sop=1, eop=0, valid=1; go to BEAT0.
  - BEAT0: ord_ready=1 -> ord_data=hold[63:0], sop=0, eop=1; go to BEAT1. ord_ready=0 -> all outputs held stable.
  - BEAT1, ord_ready=1, FIFO non-empty -> pop the next order, drive its beat0 in the next cycle with no bubble; go to BEAT0.
  - BEAT1, ord_ready=1, FIFO empty -> valid=0, data/sop/eop=0; go to IDLE.
  - BEAT1, ord_ready=0 -> outputs held.
- Latency: push at edge E into an empty FIFO with FSM IDLE -> ord_valid=1 in the cycle after edge E+1 (2 cycles).
- Throughput: 1 order per 2 cycles with ord_ready held high.
- Output stability: once ord_valid=1, data/sop/eop are unchanged until the beat is accepted. ord_valid never deasserts mid-order.
- Pop and push in the same cycle on an empty FIFO: no bypass. A push to an empty FIFO is not visible to the FSM until the next cycle.
- Reset mid-order: the beat is abandoned, queued orders are discarded, and drop_cnt is cleared.

Optional Feature:
- Macro: ORDER_TX_SEQ_EN.
- Defined:
  - A 16-bit order sequence counter (reset 0) increments on every accepted (not dropped) push.
  - The stored word has bits [127:112] replaced by the counter value at push time, so the first order after reset carries 0.
  - The counter wraps 0xFFFF->0.
- Undefined: orcb_data is stored unmodified; no counter logic.

Test Plan:
- Single order: push 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 with ready=1 -> valid 2 cycles later.
  - Beat0 0x0123456789ABCDEF with sop=1.
  - Beat1 0xFEDCBA9876543210 with eop=1.
  - Then valid=0, fifo_level returns 0.
- Back-to-back: 4 pushes on consecutive cycles, ready=1 -> 8 contiguous beats, no bubble between orders, sop/eop alternate, order preserved.
- Backpressure: ready=0 for 5 cycles while in BEAT0 -> data/sop held constant. Release -> beat1 follows next cycle.
- Overflow, FIFO_DEPTH=8, ready=0:
  - 10 pushes -> fifo_level=8, drop_cnt=2; orders 9 and 10 are the ones dropped.
  - Push while full with a simultaneous pop -> still dropped.
- Reset mid-order: assert reset_n=0 asynchronously during BEAT1 with 3 queued -> outputs go to 0 immediately. After release, no beats are emitted until a new push.
- ORDER_TX_SEQ_EN: 3 pushes with the same payload -> beat0[63:48] = 0x0000, 0x0001, 0x0002; drop_cnt saturation checked with DROP_CNT_WIDTH=2 (stops at 3).

Source files
------------

// File: rtl/order_tx.sv
// Order transmit stage: buffers strategy orders in a FIFO and serializes each into two ready/valid beats.
// Optional macro ORDER_TX_SEQ_EN stamps a 16-bit sequence number into the top bits of each stored order.
module order_tx #(
    parameter int ORD_WIDTH      = 128,
    parameter int OUT_WIDTH      = 64,
    parameter int FIFO_DEPTH     = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sef_out_valid,
    input  logic [ORD_WIDTH-1:0]          orcb_data,
    output logic                          ord_valid,
    input  logic                          ord_ready,
    output logic [OUT_WIDTH-1:0]          ord_data,
    output logic                          ord_sop,
    output logic                          ord_eop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_CNT_WIDTH-1:0]     drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t                 state, state_n;
    logic [ORD_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [ORD_WIDTH-1:0]   hold, hold_n;
    logic [ORD_WIDTH-1:0]   wr_word, rd_word;
    logic                   full, empty, push, drop, pop;
    logic                   valid_n, sop_n, eop_n;
    logic [OUT_WIDTH-1:0]   data_n;

    // Full/empty come from the registered level, so a same-cycle pop never frees room for a push.
    assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty   = (fifo_level == '0);
    assign push    = sef_out_valid && !full;
    assign drop    = sef_out_valid && full;
    assign rd_word = mem[rd_ptr];

`ifdef ORDER_TX_SEQ_EN
    logic [15:0] seq_cnt;

    assign wr_word = {seq_cnt, orcb_data[ORD_WIDTH-17:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_cnt <= '0;
        end else if (push) begin
            seq_cnt <= seq_cnt + 16'd1;
        end
    end
`else
    assign wr_word = orcb_data;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold      <= '0;
            ord_valid <= 1'b0;
            ord_data  <= '0;
            ord_sop   <= 1'b0;
            ord_eop   <= 1'b0;
        end else begin
            state     <= state_n;
            hold      <= hold_n;
            ord_valid <= valid_n;
            ord_data  <= data_n;
            ord_sop   <= sop_n;
            ord_eop   <= eop_n;
        end
    end

    // Outputs are registered; holding the defaults keeps the beat stable under backpressure.
    always_comb begin
        state_n = state;
        hold_n  = hold;
        pop     = 1'b0;
        valid_n = ord_valid;
        data_n  = ord_data;
        sop_n   = ord_sop;
        eop_n   = ord_eop;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_n  = rd_word;
                    valid_n = 1'b1;
                    data_n  = rd_word[ORD_WIDTH-1:OUT_WIDTH];
                    sop_n   = 1'b1;
                    eop_n   = 1'b0;
                    state_n = BEAT0;
                end
            end
            BEAT0: begin
                if (ord_ready) begin
                    data_n  = hold[OUT_WIDTH-1:0];
                    sop_n   = 1'b0;
                    eop_n   = 1'b1;
                    state_n = BEAT1;
                end
            end
            BEAT1: begin
                if (ord_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        hold_n  = rd_word;
                        valid_n = 1'b1;
                        data_n  = rd_word[ORD_WIDTH-1:OUT_WIDTH];
                        sop_n   = 1'b1;
                        eop_n   = 1'b0;
                        state_n = BEAT0;
                    end else begin
                        valid_n = 1'b0;
                        data_n  = '0;
                        sop_n   = 1'b0;
                        eop_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_order_tx.sv
// Self-checking bench for order_tx: directed table, corner-case sequences and randomized traffic vs a queue model.
module tb_order_tx;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         sef_out_valid = 1'b0;
    logic [127:0] orcb_data = '0;
    logic         ord_ready = 1'b0;
    logic         ord_valid, ord_sop, ord_eop;
    logic [63:0]  ord_data;
    logic [3:0]   fifo_level;
    logic [15:0]  drop_cnt;
    logic         s_valid, s_sop, s_eop;
    logic [63:0]  s_data;
    logic [3:0]   s_level;
    logic [1:0]   s_drop;

    order_tx #(.ORD_WIDTH(128), .OUT_WIDTH(64), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .sef_out_valid(sef_out_valid), .orcb_data(orcb_data),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_data(ord_data), .ord_sop(ord_sop),
        .ord_eop(ord_eop), .fifo_level(fifo_level), .drop_cnt(drop_cnt));

    order_tx #(.ORD_WIDTH(128), .OUT_WIDTH(64), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .sef_out_valid(sef_out_valid), .orcb_data(orcb_data),
        .ord_valid(s_valid), .ord_ready(ord_ready), .ord_data(s_data), .ord_sop(s_sop),
        .ord_eop(s_eop), .fifo_level(s_level), .drop_cnt(s_drop));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of stored orders, current order, beats still to send.
    logic [127:0] mq[$];
    logic [127:0] m_cur;
    int           m_beats;
    int           m_drops;
    logic [15:0]  m_seq;

    typedef struct {
        bit           sv;
        logic [127:0] d;
        bit           rdy;
        bit           e_valid;
        logic [63:0]  e_data;
        bit           e_sop;
        bit           e_eop;
        int           e_level;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur   = '0;
        m_beats = 0;
        m_drops = 0;
        m_seq   = '0;
    endtask

    task automatic model_edge();
        bit           full, pop;
        logic [127:0] w;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && (m_beats == 0 || (m_beats == 1 && ord_ready));
        if (pop) m_cur = mq.pop_front();
        if (m_beats == 2 && ord_ready)      m_beats = 1;
        else if (m_beats == 1 && ord_ready) m_beats = pop ? 2 : 0;
        else if (m_beats == 0 && pop)       m_beats = 2;
        if (sef_out_valid) begin
            if (full) begin
                m_drops++;
            end else begin
                w = orcb_data;
`ifdef ORDER_TX_SEQ_EN
                w[127:112] = m_seq;
                m_seq++;
`endif
                mq.push_back(w);
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] e_data;
        int          sat;
        e_data = (m_beats == 2) ? m_cur[127:64] : (m_beats == 1) ? m_cur[63:0] : 64'd0;
        sat    = (m_drops > 3) ? 3 : m_drops;
        chk("valid", ord_valid, m_beats > 0);
        chk("data", ord_data, e_data);
        chk("sop", ord_sop, m_beats == 2);
        chk("eop", ord_eop, m_beats == 1);
        chk("level", fifo_level, mq.size());
        chk("drop_cnt", drop_cnt, m_drops);
        chk("sat_drop_cnt", s_drop, sat);
        chk("sat_level", s_level, mq.size());
    endtask

    task automatic step(input bit sv, input logic [127:0] d, input bit rdy);
        sef_out_valid = sv;
        orcb_data     = d;
        ord_ready     = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        vec_t         tbl[4];
        logic [127:0] d1;
        logic [63:0]  hi1, held;
        int           vcount, first, last;
        logic [63:0]  sops[$];

        d1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
`ifdef ORDER_TX_SEQ_EN
        hi1 = 64'h0000_4567_89AB_CDEF;
`else
        hi1 = 64'h0123_4567_89AB_CDEF;
`endif
        tbl[0] = '{1'b1, d1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, '0, 1'b1, 1'b1, hi1, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b0, '0, 1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, 0};
        tbl[3] = '{1'b0, '0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 0};

        model_reset();
        #2;
        chk("rst_valid", ord_valid, 0);
        chk("rst_data", ord_data, 0);
        chk("rst_sop_eop", {ord_sop, ord_eop}, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single order: table of inputs and expected registered outputs.
        for (int i = 0; i < 4; i++) begin
            step(tbl[i].sv, tbl[i].d, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), ord_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_data", i), ord_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_sop", i), ord_sop, tbl[i].e_sop);
            chk($sformatf("tbl%0d_eop", i), ord_eop, tbl[i].e_eop);
            chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_level);
        end

        // Back-to-back: four pushes must produce eight contiguous beats.
        vcount = 0; first = -1; last = -1;
        for (int i = 0; i < 12; i++) begin
            step(i < 4, {64'hB2B0_0000_0000_0000 + 64'(i), 64'hB2B1_0000_0000_0000 + 64'(i)}, 1'b1);
            if (ord_valid) begin
                vcount++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("b2b_beats", vcount, 8);
        chk("b2b_contiguous", last - first + 1, 8);

        // Backpressure in BEAT0: beat held for five cycles, then beat1 next cycle.
        step(1'b1, {64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002}, 1'b0);
        step(1'b0, '0, 1'b0);
        held = ord_data;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0);
            chk("bp_hold_data", ord_data, held);
            chk("bp_hold_sop", ord_sop, 1);
        end
        step(1'b0, '0, 1'b1);
        chk("bp_beat1", {ord_eop, ord_data}, {1'b1, 64'hCAFE_0000_0000_0002});
        step(1'b0, '0, 1'b1);
        chk("bp_idle", ord_valid, 0);

        // Overflow: one order held in BEAT0, then ten pushes fill the FIFO and drop two.
        step(1'b1, {64'hAAAA_0000_0000_0000, 64'h0}, 1'b0);
        step(1'b0, '0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, {64'h0F00_0000_0000_0000 + 64'(i), 64'(i)}, 1'b0);
        end
        chk("ovf_level", fifo_level, 8);
        chk("ovf_drop", drop_cnt, 2);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        chk("ovf_drop4", drop_cnt, 4);
        chk("sat_stops_at_3", s_drop, 3);
        step(1'b0, '0, 1'b1);
        step(1'b1, '0, 1'b1);
        chk("push_pop_full_drop", drop_cnt, 5);
        chk("push_pop_full_level", fifo_level, 7);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b1);
            if (ord_valid && ord_sop) sops.push_back(ord_data);
        end
        chk("ovf_drain_count", sops.size(), 7);
        if (sops.size() == 7) chk("ovf_last_is_8", sops[6][47:0], 48'd8);

        // Reset asserted asynchronously in BEAT1 with three orders queued.
        for (int i = 0; i < 4; i++) step(1'b1, {64'hDD00_0000_0000_0000 + 64'(i), 64'(i)}, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("pre_rst_level", fifo_level, 3);
        chk("pre_rst_eop", ord_eop, 1);
        ord_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", ord_valid, 0);
        chk("mid_rst_data", ord_data, 0);
        chk("mid_rst_sop_eop", {ord_sop, ord_eop}, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1);
            if (ord_valid) vcount++;
        end
        chk("post_rst_no_beats", vcount, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 1) == 1,
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
